// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: port-id encoding, read tag, default widths.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_id_e;

  typedef struct packed {
    logic     valid;
    port_id_e port_id;
  } rd_tag_t;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags; the last stage lines up with mem_rdata.
module dmem_rd_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t tag_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_o = tag_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port single-port-memory arbiter: fixed priority to port 0 with a port-1 starvation guard.
// Optional DMEM_ARB_LOCK_EN adds m1_lock for exclusive debug-port access (atomic RMW).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAXW = 4'(MAX_WAIT);

  logic [3:0] wait_q, wait_d;
  rd_tag_t    tag_in, tag_out;
  logic       lock_act;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;

  always_comb begin
    lock_d = lock_q;
    if (m1_gnt) lock_d = m1_lock;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lock_q <= 1'b0;
    else      lock_q <= lock_d;
  end

  assign lock_act = lock_q;
`else
  assign lock_act = 1'b0;
`endif

  // Port 0 wins a collision unless port 1 has waited MAX_WAIT cycles or holds the lock.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (lock_act) begin
      m1_gnt = m1_req;
    end else if (m0_req && m1_req) begin
      if (wait_q == MAXW) m1_gnt = 1'b1;
      else                m0_gnt = 1'b1;
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_re    = ~m0_we;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_re    = ~m1_we;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_comb begin
    wait_d = '0;
    if (m1_req && !m1_gnt) wait_d = (wait_q == MAXW) ? wait_q : 4'(wait_q + 4'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end

  assign tag_in.valid   = mem_re;
  assign tag_in.port_id = m1_gnt ? PORT_DBG : PORT_CORE;

  dmem_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rst_n(rst),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );

  // Response steering: only the port that owns the emerging tag sees data.
  always_comb begin
    m0_rvalid = tag_out.valid && (tag_out.port_id == PORT_CORE);
    m1_rvalid = tag_out.valid && (tag_out.port_id == PORT_DBG);
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store stage, port 1 is a debug/loader port used for program and data preload.
- Issues at most one memory command per cycle using fixed priority to port 0, with a starvation guard for port 1.
- Tracks in-flight reads so each read response is returned to the port that issued it.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles from command to mem_rdata valid; legal range 1..4.
- MAX_WAIT, 3, consecutive denied cycles after which a pending port-1 request must win; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req  input  1  port 0 request; held stable with its fields until m0_gnt.
- m0_we  input  1  port 0: 1 = write, 0 = read.
- m0_addr  input  ADDR_W  port 0 address.
- m0_wdata  input  DATA_W  port 0 write data.
- m0_gnt  output  1  port 0 request accepted this cycle.
- m0_rvalid  output  1  port 0 read data valid.
- m0_rdata  output  DATA_W  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- mem_re  output  1  memory read strobe.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid RD_LAT cycles after mem_re.

Behaviour:
- Reset (rst=0, asynchronous):
  - Wait counter cleared to 0; tag pipeline cleared.
  - m0_rvalid, m1_rvalid and both rdata outputs = 0.
  - Gnt and mem_* outputs = 0, because they are combinational and request-qualified.
- Grant is combinational, same cycle as req:
  - Only one port requesting: that port is granted.
  - Both requesting: port 0 is granted, unless wait_cnt == MAX_WAIT, in which case port 1 is granted.
  - Neither requesting: no grant.
- Memory command, same cycle as grant:
  - mem_re = gnt & ~we; mem_we = gnt & we.
  - mem_addr and mem_wdata are muxed from the granted port; both are 0 when nothing is granted.
- Wait counter:
  - Increments when m1_req=1 and m1_gnt=0.
  - Saturates at MAX_WAIT.
  - Clears on m1_gnt, or when m1_req=0.
- Read tagging:
  - A shift register RD_LAT deep holds {valid, port_id} per cycle; it is loaded on each granted read.
  - When the tag at stage RD_LAT is valid, the matching mX_rvalid = 1 and mX_rdata = mem_rdata.
  - The other port's rvalid = 0 and its rdata = 0.
- Writes produce no response; the write completes on the grant cycle.
- Back-to-back operation:
  - A new grant and a read response may occur in the same cycle; full throughput is 1 command per cycle.
  - Interleaved reads from both ports must return in issue order, each to its own port.
- Reset mid-operation: in-flight tags are discarded; no rvalid is produced after reset release for reads issued before reset.
- A request that is not granted stays pending; the arbiter never drops or reorders accepted commands.

Optional Feature:
- DMEM_ARB_LOCK_EN: adds input m1_lock (1 bit).
  - A port-1 grant with m1_lock=1 sets a lock flag (reset 0).
  - While the flag is set, port 1 has exclusive access: port 0 is never granted, even if m1_req=0.
  - The flag clears on a port-1 grant with m1_lock=0.
  - This supports atomic read-modify-write by the debug port.
- Without the macro: no m1_lock port, no lock flag; pure priority-plus-starvation arbitration.

Decomposition:
- Shared package holds:
  - the port-id encoding (PORT_CORE=0, PORT_DBG=1);
  - the tag struct {valid, port_id};
  - default ADDR_W and DATA_W.
- One sub-module, dmem_rd_tag_pipe: the RD_LAT-deep tag shift register with async active-low clear.

Test Plan:
- Reset release, m0 reads 0x10 (RD_LAT=1, mem returns 0xDEADBEEF): m0_gnt=1 in the request cycle; m0_rvalid=1 with m0_rdata=0xDEADBEEF in the next cycle; m1_rvalid stays 0.
- Both ports request continuously, MAX_WAIT=3: grant sequence is m0,m0,m0,m1,m0,m0,m0,m1…; wait_cnt never exceeds 3.
- m1 write addr 0x20 data 0x5 while m0 is idle: mem_we=1, mem_addr=0x20, mem_wdata=0x5 in the same cycle; no rvalid on either port.
- Alternating reads m0@0x4, m1@0x8, m0@0xC with RD_LAT=3: responses arrive cycles 3, 4, 5 to m0, m1, m0 respectively.
- Assert rst low with 2 reads in flight (RD_LAT=3), release next cycle: no rvalid on either port for the following 4 cycles.
- With DMEM_ARB_LOCK_EN: m1 reads with lock=1, then m0 requests for 3 cycles, then m1 writes with lock=0: m0_gnt=0 until the cycle after the unlocking m1 write.
